// File: rtl/mux2_rr_arbiter.sv
// Two-requester packet-aware round-robin arbiter driving a shared 2:1 mux
// into a single registered output stage, with max-packet-length truncation.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  output logic             trunc_err
);

  localparam int unsigned    CNT_W    = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_src_q, out_src_d;
  logic               trunc_err_q, trunc_err_d;

  logic               gnt_vld;
  logic               gnt_sel;
  logic               sel_valid;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_last;
  logic               load;
  logic               gnt_ready;
  logic               accept;
  logic               at_max;
  logic               eop;

  // Grant: a lock pins the select; in IDLE the grant is combinational so
  // packet boundaries cost no dead cycle.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = 1'b0;
    case (state_q)
      LOCK0: begin
        gnt_vld = 1'b1;
        gnt_sel = 1'b0;
      end
      LOCK1: begin
        gnt_vld = 1'b1;
        gnt_sel = 1'b1;
      end
      default: begin
        if (in0_valid && in1_valid) begin
          gnt_vld = 1'b1;
          gnt_sel = ptr_q;
        end else if (in0_valid) begin
          gnt_vld = 1'b1;
          gnt_sel = 1'b0;
        end else if (in1_valid) begin
          gnt_vld = 1'b1;
          gnt_sel = 1'b1;
        end
      end
    endcase
  end

  // Shared 2:1 datapath mux steered by the grant.
  assign sel_valid = gnt_sel ? in1_valid : in0_valid;
  assign sel_data  = gnt_sel ? in1_data  : in0_data;
  assign sel_last  = gnt_sel ? in1_last  : in0_last;

  assign load      = !out_valid_q || out_ready;
  assign gnt_ready = gnt_vld && load && !rst;
  assign in0_ready = gnt_ready && !gnt_sel;
  assign in1_ready = gnt_ready && gnt_sel;
  assign accept    = gnt_ready && sel_valid;
  assign at_max    = (beat_cnt_q == CNT_LAST);
  assign eop       = sel_last || at_max;

  // Next-state: lock/pointer/counter sequencing and output-stage load.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    trunc_err_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = gnt_sel;
      if (eop) begin
        state_d     = IDLE;
        ptr_d       = ~gnt_sel;
        beat_cnt_d  = '0;
        out_last_d  = 1'b1;
        trunc_err_d = !sel_last;
      end else begin
        state_d    = gnt_sel ? LOCK1 : LOCK0;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        out_last_d = 1'b0;
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign trunc_err = trunc_err_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: alternation, packet locking, truncation,
// backpressure, mid-packet reset and lock hold with hand-computed expectations.
module tb_mux2_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in0_ready, in0_last;
  logic [31:0] in0_data;
  logic        in1_valid, in1_ready, in1_last;
  logic [31:0] in1_data;
  logic        out_valid, out_ready, out_last, out_src, trunc_err;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  mux2_rr_arbiter #(.WIDTH(32), .MAX_BEATS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .trunc_err (trunc_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic src, input logic last);
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chkd({tag, "_data"}, out_data, d);
    chk1({tag, "_src"}, out_src, src);
    chk1({tag, "_last"}, out_last, last);
  endtask

  initial begin
    // Reset with both requesters already valid
    rst = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 32'hA0; in0_last = 1'b1;
    in1_valid = 1'b1; in1_data = 32'hB0; in1_last = 1'b1;
    step(); step();
    chk1("rst_in0_ready", in0_ready, 1'b0);
    chk1("rst_in1_ready", in1_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkd("rst_out_data", out_data, 32'h0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_out_src", out_src, 1'b0);
    chk1("rst_trunc_err", trunc_err, 1'b0);

    // 1-beat packets from both sides alternate every cycle
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1("alt_in0_ready", in0_ready, (k % 2) == 0);
      chk1("alt_in1_ready", in1_ready, (k % 2) == 1);
      step();
      chk_out("alt", ((k % 2) == 0) ? 32'hA0 : 32'hB0, (k % 2) == 1, 1'b1);
    end

    // in0 4-beat packet stays contiguous while in1 waits
    in1_data = 32'hC0;
    for (int i = 0; i < 4; i++) begin
      in0_data = 32'(32'h10 + i);
      in0_last = (i == 3);
      #1;
      chk1("pkt_in0_ready", in0_ready, 1'b1);
      chk1("pkt_in1_ready", in1_ready, 1'b0);
      step();
      chk_out("pkt", 32'(32'h10 + i), 1'b0, i == 3);
    end
    in0_valid = 1'b0;
    step();
    chk_out("pkt_in1", 32'hC0, 1'b1, 1'b1);

    // in0 streams 18 beats without last: beat 16 truncated
    in1_valid = 1'b0;
    in0_valid = 1'b1;
    in0_last  = 1'b0;
    for (int i = 0; i < 18; i++) begin
      in0_data = 32'(32'h100 + i);
      step();
      chk_out("trunc", 32'(32'h100 + i), 1'b0, i == 15);
      chk1("trunc_err", trunc_err, i == 15);
    end
    in0_data = 32'h1FF;
    in0_last = 1'b1;
    step();
    chk_out("trunc_close", 32'h1FF, 1'b0, 1'b1);
    chk1("trunc_close_err", trunc_err, 1'b0);

    // Backpressure mid-packet on in1
    in0_valid = 1'b0;
    in1_valid = 1'b1; in1_data = 32'h20; in1_last = 1'b0;
    step();
    chk_out("bp_first", 32'h20, 1'b1, 1'b0);
    out_ready = 1'b0;
    in1_data  = 32'h21;
    in0_valid = 1'b1; in0_data = 32'hD0; in0_last = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk1("bp_in0_ready", in0_ready, 1'b0);
      chk1("bp_in1_ready", in1_ready, 1'b0);
      step();
      chk_out("bp_hold", 32'h20, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk1("bp_resume_in1_ready", in1_ready, 1'b1);
    chk1("bp_resume_in0_ready", in0_ready, 1'b0);
    step();
    chk_out("bp_next", 32'h21, 1'b1, 1'b0);
    in1_data = 32'h22; in1_last = 1'b1;
    step();
    chk_out("bp_last", 32'h22, 1'b1, 1'b1);
    in1_valid = 1'b0;
    step();
    chk_out("bp_in0", 32'hD0, 1'b0, 1'b1);

    // Reset during LOCK1 with a beat in the output stage
    in0_valid = 1'b0;
    in1_valid = 1'b1; in1_data = 32'h30; in1_last = 1'b0;
    step();
    chk_out("rl_lock", 32'h30, 1'b1, 1'b0);
    in1_data = 32'h31;
    rst = 1'b1;
    #1;
    chk1("rl_in1_ready", in1_ready, 1'b0);
    step();
    chk1("rl_out_valid", out_valid, 1'b0);
    chkd("rl_out_data", out_data, 32'h0);
    rst = 1'b0;
    in0_valid = 1'b1; in0_data = 32'h40; in0_last = 1'b1;
    in1_data = 32'h41; in1_last = 1'b1;
    #1;
    chk1("rl_in0_ready", in0_ready, 1'b1);
    chk1("rl_in1_ready2", in1_ready, 1'b0);
    step();
    chk_out("rl_first", 32'h40, 1'b0, 1'b1);
    step();
    chk_out("rl_second", 32'h41, 1'b1, 1'b1);

    // in1 lock held while in1_valid drops and in0 is waiting
    in0_valid = 1'b0;
    in1_data = 32'h50; in1_last = 1'b0;
    step();
    chk_out("hold_first", 32'h50, 1'b1, 1'b0);
    in1_valid = 1'b0;
    in0_valid = 1'b1; in0_data = 32'hE0; in0_last = 1'b1;
    for (int s = 0; s < 2; s++) begin
      #1;
      chk1("hold_in0_ready", in0_ready, 1'b0);
      step();
      chk1("hold_out_valid", out_valid, 1'b0);
    end
    in1_valid = 1'b1; in1_data = 32'h51; in1_last = 1'b1;
    step();
    chk_out("hold_last", 32'h51, 1'b1, 1'b1);
    in1_valid = 1'b0;
    step();
    chk_out("hold_in0", 32'hE0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Two-requester, packet-aware round-robin arbiter that shares one WIDTH-bit 2:1 mux datapath between two valid/ready streams and registers the winner's beat into a single output stage. It sits in front of any consumer that needs to merge two sources through the existing 2:1 mux library. It sequences the mux select from an FSM so packets are never interleaved. A beat counter enforces a maximum packet length.

## Interface
- WIDTH, 32, data width of both inputs and the output (≥1)
- MAX_BEATS, 16, maximum beats per packet before forced truncation (≥2)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in0_valid  input  1  requester 0 beat valid
- in0_ready  output  1  requester 0 beat accepted this cycle when high with in0_valid
- in0_data  input  WIDTH  requester 0 beat data
- in0_last  input  1  requester 0 final beat of packet
- in1_valid / in1_ready / in1_data / in1_last  same as above for requester 1
- out_valid  output  1  registered beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  WIDTH  registered beat data
- out_last  output  1  registered end-of-packet (forced high on truncation)
- out_src  output  1  source of registered beat (0 = in0, 1 = in1)
- trunc_err  output  1  one-cycle pulse: a packet was truncated at MAX_BEATS

## Operation
- FSM states: IDLE (no lock), LOCK0, LOCK1. Round-robin pointer ptr (1 bit, preferred requester).
- Grant g: LOCK0 → 0; LOCK1 → 1; IDLE → if only one valid, that one; if both valid, ptr; if none, no grant.
- Mux select = g; granted data/last drive the output register input; non-granted requester's ready = 0.
- load = !out_valid | out_ready. in_g_ready = grant present & load & !rst.
- Accept = in_g_valid & in_g_ready. On accept: out_data ← in_g_data, out_src ← g, out_valid ← 1, beat_cnt increments.
- If load and no accept: out_valid ← 0 (out_data/out_last/out_src hold).
- End of packet on accept if in_g_last = 1 or beat_cnt == MAX_BEATS−1. Then: state → IDLE, ptr ← ~g, beat_cnt ← 0, out_last ← 1.
- Truncation (beat_cnt == MAX_BEATS−1 and in_g_last = 0): out_last forced 1, trunc_err ← 1 for next cycle only. The rest of that requester's stream is a new packet and arbitrates normally.
- Accept without end of packet: state → LOCKg (or stays), out_last ← 0.
- beat_cnt width: clog2(MAX_BEATS). It never exceeds MAX_BEATS−1.
- Locked state with granted requester not valid: hold the lock. The other requester waits; no bubble fill.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, out_src 0, trunc_err 0, state IDLE, ptr 0, beat_cnt 0. in0_ready = in1_ready = 0 while rst high.
- Latency: accepted beat appears on out_* the next cycle.
- Throughput: one beat per cycle, including back-to-back packets from alternating requesters. There is no dead cycle at a packet boundary, because the IDLE grant is combinational.
- Stall: out_valid & !out_ready → out_* hold, both readies 0, FSM/ptr/beat_cnt hold.
- Simultaneous requests in IDLE resolve by ptr. A single requester may win consecutive packets if the other is idle.
- in_k_valid deasserting mid-packet does not release the lock.
- rst asserted mid-packet: lock, counter and pointer cleared at that edge. out_valid is 0 the following cycle, and the in-flight beat is discarded.

## Test plan
- Reset, then both valid with 1-beat packets (last=1), data 0xA0/0xB0, out_ready=1 → out sequence 0xA0(src0), 0xB0(src1), 0xA0, … alternating every cycle, no gaps.
- in0 sends 4-beat packet 0x10..0x13 while in1 valid throughout → all four in0 beats contiguous with out_src=0, then in1 beats. in1_ready stays 0 during the in0 packet.
- in0 streams MAX_BEATS+2 beats with last=0 (MAX_BEATS=16), in1 idle → beat 16 has out_last=1 and trunc_err pulses exactly one cycle with it. Beats 17–18 start a new packet.
- Backpressure: out_ready low for 3 cycles mid-packet → out_data constant, both readies 0, no beat lost or duplicated after out_ready returns.
- Reset asserted during LOCK1 with out_valid=1 → next cycle out_valid=0, ptr=0. With both valid after reset, in0 wins first.
- in1 locked, in1_valid drops for 2 cycles with in0 valid → no in0 beats until in1's last beat is accepted.
